// File: rtl/data_mem_ctrl.sv
// Data-memory controller: serves processor loads/stores from an internal word RAM
// with a fixed multi-cycle latency. Define DMEM_MMIO_EN to add a single MMIO register.
module data_mem_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 Busy
`ifdef DMEM_MMIO_EN
    ,
    output logic [WORD_SIZE-1:0] MmioOut
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state_reg;
    logic [3:0]             count_reg;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic [WORD_SIZE-1:0]   wdata_reg;
    logic                   write_reg;
    logic                   mmio_reg;
    logic                   busy_reg;
    logic [WORD_SIZE-1:0]   rd_word_reg;
    logic [WORD_SIZE-1:0]   ram [2**ADDR_BITS];

    logic                   req;
    logic                   req_mmio;
    logic                   ram_we;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic                   unused_addr_bits;

    assign req              = ReadData | WriteData;
    assign unused_addr_bits = ^DataAddr[WORD_SIZE-1:ADDR_BITS];

`ifdef DMEM_MMIO_EN
    logic [WORD_SIZE-1:0]   mmio_out_reg;
    assign req_mmio = DataAddr[WORD_SIZE-1];
`else
    assign req_mmio = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            mmio_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg  <= DataAddr[ADDR_BITS-1:0];
                        wdata_reg <= DataOut;
                        write_reg <= WriteData;
                        mmio_reg  <= req_mmio;
                        count_reg <= 4'(LATENCY - 1);
                        if (LATENCY == 1 || req_mmio) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= ACCESS;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // Completes even if the processor drops its request mid-access.
                    if (count_reg == 4'd0) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Writes commit on the edge leaving DONE, so a following read sees them.
    assign ram_we  = (state_reg == DONE) && write_reg && !mmio_reg;
    assign rd_addr = (state_reg == IDLE) ? DataAddr[ADDR_BITS-1:0] : addr_reg;

    always_ff @(posedge Clock) begin
        if (ram_we) begin
            ram[addr_reg] <= wdata_reg;
        end
        rd_word_reg <= ram[rd_addr];
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mmio_out_reg <= '0;
        end else if ((state_reg == DONE) && write_reg && mmio_reg) begin
            mmio_out_reg <= wdata_reg;
        end
    end

    assign MmioOut = mmio_out_reg;
    assign DataIn  = (state_reg == DONE) ? (mmio_reg ? mmio_out_reg : rd_word_reg) : '0;
`else
    assign DataIn  = (state_reg == DONE) ? rd_word_reg : '0;
`endif

    assign DataDone = (state_reg == IDLE) ? ~req : (state_reg == DONE);
    assign Busy     = busy_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized traffic
// checked against an array-based memory model.
module tb_data_mem_ctrl;
    localparam int LAT = 2;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        ReadData = 1'b0;
    logic        WriteData = 1'b0;
    logic [15:0] DataAddr = '0;
    logic [15:0] DataOut = '0;
    logic [15:0] DataIn;
    logic        DataDone;
    logic        Busy;
`ifdef DMEM_MMIO_EN
    logic [15:0] MmioOut;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_mmio = 16'h0000;
    logic [15:0] written_q[$];

    data_mem_ctrl #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .ReadData (ReadData),
        .WriteData(WriteData),
        .DataAddr (DataAddr),
        .DataOut  (DataOut),
        .DataIn   (DataIn),
        .DataDone (DataDone),
        .Busy     (Busy)
`ifdef DMEM_MMIO_EN
        ,
        .MmioOut  (MmioOut)
`endif
    );

    always #5 Clock = ~Clock;

    function automatic bit is_mmio(input logic [15:0] addr);
`ifdef DMEM_MMIO_EN
        return addr[15];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input logic [15:0] addr);
        return is_mmio(addr) ? 1 : LAT + 1;
    endfunction

    function automatic int exp_busy(input logic [15:0] addr);
        return is_mmio(addr) ? 0 : LAT;
    endfunction

    // Reference model: a write takes effect as a whole transaction; reads return the latest value.
    function automatic void model_write(input logic [15:0] addr, input logic [15:0] data);
        if (is_mmio(addr)) ref_mmio = data;
        else begin
            ref_mem[addr[7:0]] = data;
            written_q.push_back(addr);
        end
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        return is_mmio(addr) ? ref_mmio : ref_mem[addr[7:0]];
    endfunction

    // Presents one request in an IDLE cycle, holds it until DataDone, and reports what was seen.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, output logic [15:0] rdata,
                             output int lat, output int busy_cnt, output int din_nz,
                             output logic done0);
        @(posedge Clock); #1;
        ReadData = rd; WriteData = wr; DataAddr = addr; DataOut = wdata;
        #1;
        done0 = DataDone;
        lat = 0; busy_cnt = 0; din_nz = 0;
        while (lat <= 40) begin
            @(posedge Clock); #1;
            lat++;
            if (DataDone === 1'b1) break;
            if (Busy === 1'b1) busy_cnt++;
            if (DataIn !== 16'h0000) din_nz++;
        end
        rdata = DataIn;
        ReadData = 1'b0; WriteData = 1'b0;
        $display("txn rd=%0b wr=%0b addr=%h wdata=%h rdata=%h lat=%0d busy=%0d",
                 rd, wr, addr, wdata, rdata, lat, busy_cnt);
    endtask

    task automatic test_reset();
        Resetn = 1'b0; ReadData = 1'b1; DataAddr = 16'h0000;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (DataIn !== 16'h0000) begin errors++; $display("FAIL reset_datain: got %h expected 0000", DataIn); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        Resetn = 1'b1; #1;
        checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL reset_release_done: got %b expected 0", DataDone); end
        ReadData = 1'b0; #1;
        checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL idle_no_req_done: got %b expected 1", DataDone); end
    endtask

    task automatic test_basic();
        logic [15:0] rdv; int lat, bc, nz; logic d0;
        do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, rdv, lat, bc, nz, d0);
        model_write(16'h0010, 16'hBEEF);
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL basic_req_done: got %b expected 0", d0); end
        checks++; if (lat != LAT + 1) begin errors++; $display("FAIL basic_wr_lat: got %0d expected %0d", lat, LAT + 1); end
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'hBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected beef", rdv); end
        checks++; if (bc != LAT) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, LAT); end
        checks++; if (nz != 0) begin errors++; $display("FAIL basic_datain_idle: got %0d nonzero cycles expected 0", nz); end
        @(posedge Clock); #1;
        checks++; if (DataIn !== 16'h0000 || DataDone !== 1'b1) begin
            errors++; $display("FAIL basic_after_done: got DataIn=%h DataDone=%b expected 0000/1", DataIn, DataDone); end
    endtask

    task automatic test_alias();
        logic [15:0] rdv; int lat, bc, nz; logic d0;
        do_access(1'b0, 1'b1, 16'h0105, 16'h1234, rdv, lat, bc, nz, d0);
        model_write(16'h0105, 16'h1234);
        do_access(1'b1, 1'b0, 16'h0005, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'h1234) begin errors++; $display("FAIL alias_rd: got %h expected 1234", rdv); end
`ifndef DMEM_MMIO_EN
        do_access(1'b0, 1'b1, 16'h8040, 16'h4242, rdv, lat, bc, nz, d0);
        model_write(16'h8040, 16'h4242);
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'h4242 || lat != LAT + 1) begin
            errors++; $display("FAIL msb_ignored: got %h lat %0d expected 4242 lat %0d", rdv, lat, LAT + 1); end
`endif
    endtask

    task automatic test_both_high();
        logic [15:0] rdv; int lat, bc, nz; logic d0;
        do_access(1'b1, 1'b1, 16'h0020, 16'h00AA, rdv, lat, bc, nz, d0);
        model_write(16'h0020, 16'h00AA);
        do_access(1'b1, 1'b0, 16'h0020, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'h00AA) begin errors++; $display("FAIL both_high_write_wins: got %h expected 00aa", rdv); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] rdv; int lat, bc, nz; logic d0;
        do_access(1'b0, 1'b1, 16'h0030, 16'h1111, rdv, lat, bc, nz, d0);
        model_write(16'h0030, 16'h1111);
        @(posedge Clock); #1;
        WriteData = 1'b1; DataAddr = 16'h0030; DataOut = 16'h5555;
        @(posedge Clock); #1;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_in_access: got Busy=%b expected 1", Busy); end
        Resetn = 1'b0; #1;
        WriteData = 1'b0;
        checks++; if (Busy !== 1'b0 || DataIn !== 16'h0000) begin
            errors++; $display("FAIL abort_reset_state: got Busy=%b DataIn=%h expected 0/0000", Busy, DataIn); end
        #2 Resetn = 1'b1;
        ref_mmio = 16'h0000;
        @(posedge Clock); #1;
        checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL abort_idle_done: got %b expected 1", DataDone); end
        do_access(1'b1, 1'b0, 16'h0030, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'h1111) begin errors++; $display("FAIL abort_write_lost: got %h expected 1111", rdv); end
    endtask

    task automatic test_flush();
        logic [15:0] rdv; int lat, bc, nz; logic d0;
        @(posedge Clock); #1;
        WriteData = 1'b1; DataAddr = 16'h0041; DataOut = 16'h7777;
        @(posedge Clock); #1;
        WriteData = 1'b0; DataAddr = 16'h00FF; DataOut = 16'h0000;
        #1;
        checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL flush_access_done: got %b expected 0", DataDone); end
        repeat (LAT + 1) @(posedge Clock);
        model_write(16'h0041, 16'h7777);
        do_access(1'b1, 1'b0, 16'h0041, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'h7777) begin errors++; $display("FAIL flush_write_committed: got %h expected 7777", rdv); end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        logic [15:0] rdv; int lat, bc, nz; logic d0;
        do_access(1'b0, 1'b1, 16'h8000, 16'h00F0, rdv, lat, bc, nz, d0);
        model_write(16'h8000, 16'h00F0);
        checks++; if (lat != 1) begin errors++; $display("FAIL mmio_wr_lat: got %0d expected 1", lat); end
        @(posedge Clock); #1;
        checks++; if (MmioOut !== 16'h00F0) begin errors++; $display("FAIL mmio_out: got %h expected 00f0", MmioOut); end
        do_access(1'b1, 1'b0, 16'h8001, 16'h0000, rdv, lat, bc, nz, d0);
        checks++; if (rdv !== 16'h00F0 || lat != 1) begin
            errors++; $display("FAIL mmio_rd: got %h lat %0d expected 00f0 lat 1", rdv, lat); end
    endtask
`endif

    task automatic test_random();
        logic [15:0] rdv, addr, data, expd; int lat, bc, nz; logic d0;
        int op;
        for (int i = 0; i < 40; i++) begin
            op   = $urandom_range(0, 2);
            data = 16'($urandom);
            if (op == 1) begin
                addr = written_q[$urandom_range(0, written_q.size() - 1)];
                addr[14:8] = 7'($urandom);
                if ($urandom_range(0, 3) == 0) addr = {1'b1, 15'($urandom)};
`ifdef DMEM_MMIO_EN
`else
                addr[15] = 1'($urandom);
`endif
                expd = model_read(addr);
                do_access(1'b1, 1'b0, addr, data, rdv, lat, bc, nz, d0);
                checks++; if (rdv !== expd) begin
                    errors++; $display("FAIL rand_rd_data[%0d]: addr %h got %h expected %h", i, addr, rdv, expd); end
            end else begin
                addr = 16'($urandom);
                do_access(op == 2, 1'b1, addr, data, rdv, lat, bc, nz, d0);
                model_write(addr, data);
            end
            checks++; if (lat != exp_lat(addr) || bc != exp_busy(addr) || nz != 0 || d0 !== 1'b0) begin
                errors++; $display("FAIL rand_timing[%0d]: addr %h got lat=%0d busy=%0d nz=%0d d0=%b expected lat=%0d busy=%0d nz=0 d0=0",
                                   i, addr, lat, bc, nz, d0, exp_lat(addr), exp_busy(addr)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alias();
        test_both_high();
        test_reset_abort();
        test_flush();
`ifdef DMEM_MMIO_EN
        test_mmio();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
